score_collector: RTL and testbench

//  Producer side of the argmax classifier interface. Accepts the output layer's

---
 rtl/score_collector.sv | 146 ++++++++++++++
 tb/tb_score_collector.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/score_collector.sv
// rtl/score_collector.sv - packs streamed class scores into the argmax bus and handshakes one frame at a time
// Optional COLLECT_LAST_CHECK_EN: enforce s_last on the final beat, flag sticky err_frame otherwise.
module score_collector #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 32,
    parameter int CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_valid,
    input  logic [SCORE_W-1:0]             s_data,
    input  logic                           s_last,
    output logic                           s_ready,
    input  logic                           flush,
    input  logic                           max_valid,
    output logic [NUM_CLASSES*SCORE_W-1:0] data,
    output logic                           enable,
    output logic                           busy,
    output logic [CNT_W-1:0]               frame_count,
    output logic                           err_frame
);

    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_COLLECT,
        ST_FIRE,
        ST_WAIT
    } state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_CLASSES*SCORE_W-1:0]   data_q, data_d;
    logic                             ready_q, ready_d;
    logic                             enable_q, enable_d;
    logic                             busy_q, busy_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    logic accept;
    logic last_beat;
    logic frame_err;
    logic beat_ok;

    // ready_q is only ever high in COLLECT, so it doubles as the state qualifier
    assign accept    = s_valid & ready_q;
    assign last_beat = (idx_q == LAST_IDX);

`ifdef COLLECT_LAST_CHECK_EN
    logic err_q, err_d;
    assign frame_err = accept & ~flush & (s_last != last_beat);
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign frame_err     = 1'b0;
`endif

    assign beat_ok = accept & ~flush & ~frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_COLLECT;
            ST_COLLECT: if (beat_ok && last_beat) state_d = ST_FIRE;
            ST_FIRE:    state_d = ST_WAIT;
            ST_WAIT:    if (max_valid) state_d = ST_COLLECT;
            default:    state_d = ST_INIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        ready_d  = (state_d == ST_COLLECT);
        enable_d = (state_d == ST_FIRE);
        busy_d   = (state_d == ST_FIRE) || (state_d == ST_WAIT);
        count_d  = enable_d ? count_q + CNT_W'(1) : count_q;
    end

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
`ifdef COLLECT_LAST_CHECK_EN
        err_d  = err_q;
`endif
        if (state_q == ST_COLLECT) begin
            if (flush) begin
                idx_d = '0;
            end else if (frame_err) begin
                idx_d = '0;
`ifdef COLLECT_LAST_CHECK_EN
                err_d = 1'b1;
`endif
            end else if (accept) begin
                data_d[int'(idx_q)*SCORE_W +: SCORE_W] = s_data;
                idx_d = last_beat ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            idx_q    <= idx_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            count_q  <= count_d;
        end
    end

`ifdef COLLECT_LAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err_frame = err_q;
`else
    assign err_frame = 1'b0;
`endif

    assign s_ready     = ready_q;
    assign enable      = enable_q;
    assign busy        = busy_q;
    assign frame_count = count_q;
    assign data        = data_q;

endmodule

// File: tb/tb_score_collector.sv
// tb/tb_score_collector.sv - directed self-checking bench for score_collector
module tb_score_collector;

    localparam int N = 10;
    localparam int W = 32;
    localparam int C = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic [W-1:0]   s_data = '0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic           flush = 1'b0;
    logic           max_valid = 1'b0;
    logic [N*W-1:0] data;
    logic           enable;
    logic           busy;
    logic [C-1:0]   frame_count;
    logic           err_frame;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    score_collector #(.NUM_CLASSES(N), .SCORE_W(W), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .flush(flush), .max_valid(max_valid), .data(data),
        .enable(enable), .busy(busy), .frame_count(frame_count), .err_frame(err_frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (enable) en_cnt++;

    task automatic check(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] frame_of(input int base);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(base + k);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns 1ns after the edge that accepted it
    task automatic beat(input int value, input logic last);
        int t;
        s_valid = 1'b1;
        s_data  = W'(value);
        s_last  = last;
        t = 0;
        while (!s_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("ready_timeout", 0, 1);
        tick();
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int k = 0; k < N; k++) begin
            beat(base + k, (k == N - 1));
            if (gaps && (k % 4) != 0 && k != N - 1) begin
                s_valid = 1'b0;
                repeat (k % 4) tick();
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_frame();
        max_valid = 1'b1;
        tick();
        max_valid = 1'b0;
    endtask

    initial begin
        int e0;
        int hi_cnt;

        #12;
        check("rst_ready", s_ready, 0);
        check("rst_data", data, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("init_ready", s_ready, 1);

        // back-to-back frame 0..9
        e0 = en_cnt;
        send_frame(0, 1'b0);
        check("t2_enable_hi", enable, 1);
        check("t2_ready_lo", s_ready, 0);
        check("t2_busy", busy, 1);
        check("t2_data", data, frame_of(0));
        check("t2_word9", data[319:288], 9);
        check("t2_word0", data[31:0], 0);
        tick();
        check("t2_enable_lo", enable, 0);
        check("t2_count", frame_count, 1);
        check("t2_one_enable", en_cnt - e0, 1);
        release_frame();
        check("t2_ready_back", s_ready, 1);
        check("t2_busy_lo", busy, 0);

        // same scores with gaps
        e0 = en_cnt;
        send_frame(0, 1'b1);
        tick();
        check("t3_data", data, frame_of(0));
        check("t3_one_enable", en_cnt - e0, 1);
        check("t3_count", frame_count, 2);
        release_frame();

        // four beats, flush with a live beat, then a full frame
        e0 = en_cnt;
        for (int k = 0; k < 4; k++) beat(100 + k, 1'b0);
        s_data  = W'(555);
        flush   = 1'b1;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        tick();
        check("t4_no_early_enable", en_cnt - e0, 0);
        send_frame(-32, 1'b0);
        tick();
        check("t4_data", data, frame_of(-32));
        check("t4_word0", data[31:0], 32'hFFFF_FFE0);
        check("t4_word9", data[319:288], 32'hFFFF_FFE9);
        check("t4_one_enable", en_cnt - e0, 1);

        // stall in WAIT with s_valid asserted
        hi_cnt  = 0;
        s_valid = 1'b1;
        s_data  = W'(777);
        for (int c = 0; c < 50; c++) begin
            tick();
            if (s_ready) hi_cnt++;
        end
        s_valid = 1'b0;
        check("t5_ready_held_lo", hi_cnt, 0);
        check("t5_data_frozen", data, frame_of(-32));
        check("t5_busy", busy, 1);
        release_frame();
        check("t5_ready_after_max", s_ready, 1);

        // reset in the middle of WAIT
        send_frame(50, 1'b0);
        tick();
        tick();
        check("t1_in_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t1_enable", enable, 0);
        check("t1_busy", busy, 0);
        check("t1_ready", s_ready, 0);
        check("t1_data", data, 0);
        check("t1_count", frame_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("t1_ready_after_rst", s_ready, 1);

`ifdef COLLECT_LAST_CHECK_EN
        e0 = en_cnt;
        for (int k = 0; k < 6; k++) beat(200 + k, (k == 5));
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        check("t6_err_set", err_frame, 1);
        check("t6_no_enable", en_cnt - e0, 0);
        send_frame(300, 1'b0);
        tick();
        check("t6_clean_fire", en_cnt - e0, 1);
        check("t6_data", data, frame_of(300));
        check("t6_err_sticky", err_frame, 1);
        check("t6_count", frame_count, 1);
`else
        e0 = en_cnt;
        for (int k = 0; k < N; k++) beat(400 + k, (k == 5));
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        check("nolast_fire", en_cnt - e0, 1);
        check("nolast_data", data, frame_of(400));
        check("nolast_err_zero", err_frame, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
